// File: rtl/game_ctrl.sv
// Game flow controller: tracks level, lives and score and sequences the
// IDLE / PLAY / LEVEL_UP / GAME_OVER phases, paced by VGA frame ticks.
module game_ctrl #(
    parameter int unsigned LIVES_INIT  = 3,
    parameter int unsigned MAX_LEVEL   = 4,
    parameter int unsigned HOLD_FRAMES = 120,
    parameter int unsigned POINTS      = 10
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        start_button,
    input  logic        ship_hit,
    input  logic        enemy_killed,
    input  logic        wave_cleared,
    output logic [3:0]  level,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [1:0]  state,
    output logic        game_active,
    output logic        win
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StPlay     = 2'd1,
        StLevelUp  = 2'd2,
        StGameOver = 2'd3
    } state_e;

    localparam logic [1:0]  LivesInit  = 2'(LIVES_INIT);
    localparam logic [3:0]  MaxLevel   = 4'(MAX_LEVEL);
    localparam logic [7:0]  HoldFrames = 8'(HOLD_FRAMES);
    localparam logic [16:0] Points     = 17'(POINTS);

    state_e      state_q;
    logic [3:0]  level_q;
    logic [1:0]  lives_q;
    logic [15:0] score_q;
    logic        win_q;
    logic        active_q;
    logic [7:0]  frame_cnt_q;
    logic        vsync_q;
    logic        start_q;

    logic        frame_tick;
    logic        start_edge;
    logic [16:0] score_inc;
    logic [15:0] score_sat;
    logic [7:0]  frame_cnt_inc;
    logic        hold_done;

    always_comb begin
        frame_tick    = vsync_in & ~vsync_q;
        start_edge    = start_button & ~start_q;
        score_inc     = {1'b0, score_q} + Points;
        score_sat     = score_inc[16] ? 16'hFFFF : score_inc[15:0];
        frame_cnt_inc = frame_cnt_q + 8'd1;
        hold_done     = (frame_cnt_q == HoldFrames);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= StIdle;
            level_q     <= 4'd0;
            lives_q     <= 2'd0;
            score_q     <= 16'd0;
            win_q       <= 1'b0;
            active_q    <= 1'b0;
            frame_cnt_q <= 8'd0;
            // Track live inputs so a level held high through reset is not an edge.
            vsync_q     <= vsync_in;
            start_q     <= start_button;
        end else begin
            vsync_q <= vsync_in;
            start_q <= start_button;
            case (state_q)
                StIdle: begin
                    if (start_edge) begin
                        state_q  <= StPlay;
                        level_q  <= 4'd1;
                        lives_q  <= LivesInit;
                        score_q  <= 16'd0;
                        win_q    <= 1'b0;
                        active_q <= 1'b1;
                    end
                end
                StPlay: begin
                    if (enemy_killed) begin
                        score_q <= score_sat;
                    end
                    // A lethal hit overrides a simultaneous wave clear.
                    if (ship_hit && lives_q <= 2'd1) begin
                        lives_q     <= 2'd0;
                        state_q     <= StGameOver;
                        win_q       <= 1'b0;
                        active_q    <= 1'b0;
                        frame_cnt_q <= 8'd0;
                    end else begin
                        if (ship_hit) begin
                            lives_q <= lives_q - 2'd1;
                        end
                        if (wave_cleared) begin
                            frame_cnt_q <= 8'd0;
                            active_q    <= 1'b0;
                            if (level_q < MaxLevel) begin
                                state_q <= StLevelUp;
                            end else begin
                                state_q <= StGameOver;
                                win_q   <= 1'b1;
                            end
                        end
                    end
                end
                StLevelUp: begin
                    if (frame_tick) begin
                        frame_cnt_q <= frame_cnt_inc;
                        if (frame_cnt_inc == HoldFrames) begin
                            level_q  <= level_q + 4'd1;
                            state_q  <= StPlay;
                            active_q <= 1'b1;
                        end
                    end
                end
                StGameOver: begin
                    if (start_edge && hold_done) begin
                        state_q <= StIdle;
                    end else if (frame_tick && !hold_done) begin
                        frame_cnt_q <= frame_cnt_inc;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign level       = level_q;
    assign lives       = lives_q;
    assign score       = score_q;
    assign state       = state_q;
    assign game_active = active_q;
    assign win         = win_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios with fixed expectations,
// then a long random run compared against a game-rules reference model.
module tb_game_ctrl;

    localparam int LIVES = 3;
    localparam int MAXL  = 4;
    localparam int HOLD  = 2;
    localparam int PTS   = 10;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync_in = 1'b0;
    logic        start_button = 1'b0;
    logic        ship_hit = 1'b0;
    logic        enemy_killed = 1'b0;
    logic        wave_cleared = 1'b0;
    logic [3:0]  level;
    logic [1:0]  lives;
    logic [15:0] score;
    logic [1:0]  state;
    logic        game_active;
    logic        win;

    int errors = 0;
    int checks = 0;

    // Reference model state, expressed in game terms.
    int  m_phase = 0;   // 0 idle, 1 play, 2 level-up pause, 3 game over
    int  m_level = 0;
    int  m_lives = 0;
    int  m_score = 0;
    int  m_win = 0;
    int  m_frames = 0;
    bit  m_prev_vsync = 0;
    bit  m_prev_start = 0;

    game_ctrl #(
        .LIVES_INIT (LIVES),
        .MAX_LEVEL  (MAXL),
        .HOLD_FRAMES(HOLD),
        .POINTS     (PTS)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .vsync_in    (vsync_in),
        .start_button(start_button),
        .ship_hit    (ship_hit),
        .enemy_killed(enemy_killed),
        .wave_cleared(wave_cleared),
        .level       (level),
        .lives       (lives),
        .score       (score),
        .state       (state),
        .game_active (game_active),
        .win         (win)
    );

    always #5 pclk = ~pclk;

    task automatic model_update();
        bit tick;
        bit press;
        tick  = vsync_in && !m_prev_vsync;
        press = start_button && !m_prev_start;
        if (rst) begin
            m_phase = 0; m_level = 0; m_lives = 0; m_score = 0; m_win = 0; m_frames = 0;
        end else if (m_phase == 0) begin
            if (press) begin
                m_phase = 1; m_level = 1; m_lives = LIVES; m_score = 0; m_win = 0;
            end
        end else if (m_phase == 1) begin
            if (enemy_killed) m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
            if (ship_hit && m_lives == 1) begin
                m_lives = 0; m_phase = 3; m_win = 0; m_frames = 0;
            end else begin
                if (ship_hit) m_lives = m_lives - 1;
                if (wave_cleared) begin
                    m_frames = 0;
                    if (m_level == MAXL) begin
                        m_phase = 3; m_win = 1;
                    end else begin
                        m_phase = 2;
                    end
                end
            end
        end else if (m_phase == 2) begin
            if (tick) begin
                m_frames++;
                if (m_frames == HOLD) begin
                    m_level++; m_phase = 1;
                end
            end
        end else begin
            if (press && m_frames >= HOLD) m_phase = 0;
            else if (tick && m_frames < HOLD) m_frames++;
        end
        m_prev_vsync = vsync_in;
        m_prev_start = start_button;
    endtask

    // Advance one clock with the currently driven inputs; sample 1 ns after the edge.
    task automatic step();
        model_update();
        @(posedge pclk);
        #1;
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vsync_in = 1'b1; step();
            vsync_in = 1'b0; step();
        end
    endtask

    task automatic press_start();
        start_button = 1'b0; step();
        start_button = 1'b1; step();
    endtask

    task automatic clear_wave_and_wait();
        wave_cleared = 1'b1; step();
        wave_cleared = 1'b0;
        frame_ticks(HOLD);
    endtask

    // From GAME_OVER: wait out the hold, return to IDLE, start a new game.
    task automatic new_game_from_over();
        frame_ticks(HOLD);
        press_start();
        press_start();
    endtask

    task automatic test_reset();
        rst = 1'b1; step(); step();
        rst = 1'b0;
        checks++;
        if ({state, level, lives, score, win, game_active} !== 26'd0) begin
            errors++;
            $display("FAIL reset: state=%0d level=%0d lives=%0d score=%0d win=%0d active=%0d, want all 0",
                     state, level, lives, score, win, game_active);
        end
        step();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle_hold: state=%0d want 0", state);
        end
    endtask

    task automatic test_start_score();
        start_button = 1'b1; step();
        checks++;
        if (state !== 2'd1 || level !== 4'd1 || lives !== 2'd3 || score !== 16'd0
            || game_active !== 1'b1 || win !== 1'b0) begin
            errors++;
            $display("FAIL start: state=%0d level=%0d lives=%0d score=%0d active=%0d win=%0d, want 1 1 3 0 1 0",
                     state, level, lives, score, game_active, win);
        end
        for (int i = 0; i < 3; i++) begin
            enemy_killed = 1'b1; step();
            enemy_killed = 1'b0; step();
        end
        checks++;
        if (score !== 16'd30 || state !== 2'd1) begin
            errors++;
            $display("FAIL score3: score=%0d state=%0d, want 30 1", score, state);
        end
    endtask

    task automatic test_level_up();
        wave_cleared = 1'b1; step();
        wave_cleared = 1'b0;
        checks++;
        if (state !== 2'd2 || game_active !== 1'b0 || level !== 4'd1) begin
            errors++;
            $display("FAIL levelup_enter: state=%0d active=%0d level=%0d, want 2 0 1",
                     state, game_active, level);
        end
        enemy_killed = 1'b1; ship_hit = 1'b1;
        vsync_in = 1'b1; step();
        enemy_killed = 1'b0; ship_hit = 1'b0;
        vsync_in = 1'b0; step();
        checks++;
        if (state !== 2'd2 || score !== 16'd30 || lives !== 2'd3) begin
            errors++;
            $display("FAIL levelup_hold: state=%0d score=%0d lives=%0d, want 2 30 3",
                     state, score, lives);
        end
        vsync_in = 1'b1; step();
        checks++;
        if (state !== 2'd1 || level !== 4'd2 || game_active !== 1'b1) begin
            errors++;
            $display("FAIL levelup_exit: state=%0d level=%0d active=%0d, want 1 2 1",
                     state, level, game_active);
        end
        vsync_in = 1'b0; step();
    endtask

    task automatic test_lose();
        ship_hit = 1'b1; step(); ship_hit = 1'b0;
        checks++;
        if (lives !== 2'd2 || state !== 2'd1) begin
            errors++;
            $display("FAIL hit1: lives=%0d state=%0d, want 2 1", lives, state);
        end
        step();
        ship_hit = 1'b1; step(); ship_hit = 1'b0;
        checks++;
        if (lives !== 2'd1 || state !== 2'd1) begin
            errors++;
            $display("FAIL hit2: lives=%0d state=%0d, want 1 1", lives, state);
        end
        ship_hit = 1'b1; step(); ship_hit = 1'b0;
        checks++;
        if (lives !== 2'd0 || state !== 2'd3 || win !== 1'b0 || game_active !== 1'b0) begin
            errors++;
            $display("FAIL hit3: lives=%0d state=%0d win=%0d active=%0d, want 0 3 0 0",
                     lives, state, win, game_active);
        end
        ship_hit = 1'b1; enemy_killed = 1'b1; step();
        ship_hit = 1'b0; enemy_killed = 1'b0;
        checks++;
        if (lives !== 2'd0 || state !== 2'd3 || score !== 16'd30 || level !== 4'd2) begin
            errors++;
            $display("FAIL hit4: lives=%0d state=%0d score=%0d level=%0d, want 0 3 30 2",
                     lives, state, score, level);
        end
    endtask

    task automatic test_restart();
        press_start();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL over_early0: state=%0d want 3", state);
        end
        start_button = 1'b0;
        frame_ticks(1);
        press_start();
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL over_early1: state=%0d want 3", state);
        end
        start_button = 1'b0;
        frame_ticks(1);
        press_start();
        checks++;
        if (state !== 2'd0 || level !== 4'd2 || score !== 16'd30 || win !== 1'b0) begin
            errors++;
            $display("FAIL over_exit: state=%0d level=%0d score=%0d win=%0d, want 0 2 30 0",
                     state, level, score, win);
        end
        step(); step(); step();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL held_start: state=%0d want 0", state);
        end
        press_start();
        checks++;
        if (state !== 2'd1 || level !== 4'd1 || lives !== 2'd3 || score !== 16'd0) begin
            errors++;
            $display("FAIL restart: state=%0d level=%0d lives=%0d score=%0d, want 1 1 3 0",
                     state, level, lives, score);
        end
    endtask

    task automatic test_win();
        for (int l = 2; l <= MAXL; l++) begin
            clear_wave_and_wait();
            checks++;
            if (level !== 4'(l) || state !== 2'd1) begin
                errors++;
                $display("FAIL win_level: level=%0d state=%0d, want %0d 1", level, state, l);
            end
        end
        wave_cleared = 1'b1; step(); wave_cleared = 1'b0;
        checks++;
        if (state !== 2'd3 || win !== 1'b1 || game_active !== 1'b0 || level !== 4'd4) begin
            errors++;
            $display("FAIL win: state=%0d win=%0d active=%0d level=%0d, want 3 1 0 4",
                     state, win, game_active, level);
        end
    endtask

    task automatic test_priority();
        new_game_from_over();
        ship_hit = 1'b1; step(); ship_hit = 1'b0; step();
        ship_hit = 1'b1; step(); ship_hit = 1'b0;
        checks++;
        if (lives !== 2'd1 || state !== 2'd1) begin
            errors++;
            $display("FAIL prio_setup: lives=%0d state=%0d, want 1 1", lives, state);
        end
        ship_hit = 1'b1; wave_cleared = 1'b1; enemy_killed = 1'b1; step();
        ship_hit = 1'b0; wave_cleared = 1'b0; enemy_killed = 1'b0;
        checks++;
        if (state !== 2'd3 || win !== 1'b0 || lives !== 2'd0 || score !== 16'd10) begin
            errors++;
            $display("FAIL prio: state=%0d win=%0d lives=%0d score=%0d, want 3 0 0 10",
                     state, win, lives, score);
        end
    endtask

    task automatic test_saturation();
        new_game_from_over();
        enemy_killed = 1'b1;
        for (int i = 0; i < 6553; i++) step();
        enemy_killed = 1'b0; step();
        checks++;
        if (score !== 16'd65530) begin
            errors++;
            $display("FAIL sat_preset: score=%0d want 65530", score);
        end
        enemy_killed = 1'b1; step();
        checks++;
        if (score !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_clip: score=%0d want 65535", score);
        end
        step(); enemy_killed = 1'b0;
        checks++;
        if (score !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: score=%0d want 65535", score);
        end
    endtask

    task automatic test_reset_mid();
        clear_wave_and_wait();
        clear_wave_and_wait();
        wave_cleared = 1'b1; step(); wave_cleared = 1'b0;
        checks++;
        if (state !== 2'd2 || level !== 4'd3) begin
            errors++;
            $display("FAIL mid_setup: state=%0d level=%0d, want 2 3", state, level);
        end
        rst = 1'b1; vsync_in = 1'b1; step();
        checks++;
        if ({state, level, lives, score, win, game_active} !== 26'd0) begin
            errors++;
            $display("FAIL mid_reset: state=%0d level=%0d lives=%0d score=%0d win=%0d active=%0d, want all 0",
                     state, level, lives, score, win, game_active);
        end
        rst = 1'b0; step();
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL reset_no_edge: state=%0d want 0 with start held", state);
        end
        vsync_in = 1'b0; start_button = 1'b0; step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 5000; i++) begin
            rst          = ($urandom_range(399) == 0);
            if ($urandom_range(2) == 0) vsync_in = ~vsync_in;
            if ($urandom_range(15) == 0) start_button = ~start_button;
            ship_hit     = ($urandom_range(19) == 0);
            enemy_killed = ($urandom_range(3) == 0);
            wave_cleared = ($urandom_range(11) == 0);
            step();
            checks++;
            if (state !== 2'(m_phase) || level !== 4'(m_level) || lives !== 2'(m_lives)
                || score !== 16'(m_score) || win !== 1'(m_win)
                || game_active !== (m_phase == 1)) begin
                errors++;
                $display("FAIL random[%0d]: got st=%0d lv=%0d li=%0d sc=%0d w=%0d a=%0d want st=%0d lv=%0d li=%0d sc=%0d w=%0d a=%0d",
                         i, state, level, lives, score, win, game_active,
                         m_phase, m_level, m_lives, m_score, m_win, m_phase == 1);
            end
        end
        rst = 1'b0; ship_hit = 1'b0; enemy_killed = 1'b0; wave_cleared = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_score();
        test_level_up();
        test_lose();
        test_restart();
        test_win();
        test_priority();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
